uart_tx_queue: RTL
==================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth = 2**DEPTH_LOG2 bytes (16).
REQ-002 SHALL have port sys_clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_data  input  8  byte from bus/CPU to be queued.
REQ-005 SHALL have port in_wr  input  1  push strobe, one byte per cycle high.
REQ-006 SHALL have port in_full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-007 SHALL have port in_count  output  DEPTH_LOG2+1  bytes currently queued.
REQ-008 SHALL have port overflow  output  1  sticky: push attempted while full.
REQ-009 SHALL have port ovf_clr  input  1  clears overflow.
REQ-010 SHALL have port tx_data  output  8  byte to the UART transceiver.
REQ-011 SHALL have port tx_wr  output  1  one-cycle launch strobe to the transceiver.
REQ-012 SHALL have port tx_done  input  1  one-cycle pulse from transceiver, frame complete.
REQ-013 SHALL have port idle  output  1  queue empty and no frame in flight.

Function
REQ-014 SHALL store bytes in a circular buffer with read/write pointers of DEPTH_LOG2 bits, wrapping from 2**DEPTH_LOG2-1 to 0.
REQ-015 SHALL accept a push when in_wr=1 and in_full=0 as evaluated before the edge; in_count increments by 1.
REQ-016 SHALL drop in_data when in_wr=1 and in_full=1, leave pointers/count unchanged, and set overflow; a pop in the same cycle does not rescue the push.
REQ-017 SHALL, on simultaneous accepted push and pop, leave in_count unchanged and advance both pointers.
REQ-018 SHALL clear overflow on ovf_clr=1; if set and clear coincide, set wins.
REQ-019 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-020 SHALL, in IDLE with in_count!=0, pop the head byte into registered tx_data, drive tx_wr=1 for exactly the next cycle, and move to BUSY.
REQ-021 SHALL keep tx_data stable from launch until tx_done, since the transceiver does not back-pressure tx_wr.
REQ-022 SHALL, in BUSY, never assert tx_wr; on tx_done=1 move to IDLE.
REQ-023 SHALL ignore tx_done while in IDLE.
REQ-024 SHALL launch the next queued byte no earlier than one cycle after tx_done (minimum gap: tx_done cycle, IDLE evaluation cycle, then tx_wr).
REQ-025 SHALL, for a push into an empty FIFO in IDLE accepted at edge N, produce tx_wr=1 in the cycle following edge N+1 (latency 2 edges).
REQ-026 SHALL drive idle=1 exactly when state=IDLE and in_count=0 and tx_wr=0.
REQ-027 SHALL send bytes in push order with no duplication or loss except REQ-016 drops.

Reset
REQ-028 SHALL, on sys_rst=1, set pointers=0, in_count=0, in_full=0, overflow=0, tx_wr=0, tx_data=8'h00, state=IDLE, idle=1.
REQ-029 SHALL, on reset mid-frame (BUSY), discard queued bytes and return to IDLE without waiting for tx_done; a later stray tx_done is ignored per REQ-023.
REQ-030 SHALL give reset priority over in_wr, ovf_clr and tx_done in the same cycle.

Verification
REQ-031 Single byte: push 8'h41 into empty queue at edge N -> tx_wr=1, tx_data=8'h41 after edge N+1; BUSY; tx_done -> idle=1 next cycle.
REQ-032 Ordering: push 8'h01..8'h05 back-to-back, tx_done 20 cycles after each tx_wr -> exactly 5 tx_wr pulses, data 01..05 in order, no tx_wr while BUSY.
REQ-033 Full/overflow: with tx_done withheld, push 18 bytes (DEPTH_LOG2=4) -> first launched, next 16 queued, in_full=1, in_count=16, 18th dropped, overflow=1; ovf_clr -> overflow=0.
REQ-034 Set/clear collision: full FIFO, in_wr=1 and ovf_clr=1 same cycle -> overflow=1, in_count=16.
REQ-035 Wrap-around: push/drain 40 bytes with random tx_done delays -> pointers wrap twice, output sequence equals input sequence.
REQ-036 Reset mid-frame: 3 bytes queued, BUSY, assert sys_rst one cycle -> in_count=0, tx_wr=0, idle=1; subsequent tx_done pulse causes no tx_wr.

Source files
------------

// File: rtl/uart_tx_queue.sv
`default_nettype none
// uart_tx_queue: circular byte FIFO feeding a UART transceiver, one frame in flight.
// Rev 1.0

module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [7:0]            in_data,
  input  logic                  in_wr,
  output logic                  in_full,
  output logic [DEPTH_LOG2:0]   in_count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  input  logic                  tx_done,
  output logic                  idle
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push, pop;

  // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
  assign in_full = (in_count == FULL_COUNT);
  assign push    = in_wr && !in_full;
  assign idle    = (state == IDLE) && (in_count == '0) && !tx_wr;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (in_count != '0) begin
          pop        = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   in_count <= in_count + 1'b1;
        2'b01:   in_count <= in_count - 1'b1;
        default: in_count <= in_count;
      endcase
    end
  end

  // tx_data is only loaded on launch, so it holds steady for the whole frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_wr   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_wr <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)                overflow <= 1'b0;
    else if (in_wr && in_full)  overflow <= 1'b1;
    else if (ovf_clr)           overflow <= 1'b0;
  end

endmodule

`default_nettype wire
